// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus issue FSM that drives a fixed-latency ALU and returns its results in order.

// Generic synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at rd_dat on the edge after the push.
// Backpressure: push is ignored when full and pop is ignored when empty, even if both happen in one cycle.
module alu_cmd_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_dat,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_dat  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// Issues buffered {op,B,A} commands to the ALU one at a time and returns the sampled results.
// Latency: operands update one edge after the command reaches the FIFO head; result sampled ALU_LATENCY edges later.
// Backpressure: cmd_ready is !full from registered state; a stalled response holds operands and blocks further issue.
module alu_cmd_issuer #(
   parameter int DEPTH       = 4,
   parameter int ALU_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [10:0] cmd_data,
   output logic        cmd_ready,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [7:0]  alu_result,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   input  logic        rsp_ready,
   output logic        busy,
   output logic [7:0]  rsp_count
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  lat_cnt;
   logic [10:0] head_dat;
   logic        fifo_full;
   logic        fifo_empty;
   logic        issue_vld;

   // Pop only from IDLE, so at most one command is ever in flight at the ALU.
   assign issue_vld = (state == IDLE) && !fifo_empty;
   assign cmd_ready = !fifo_full;
   assign busy      = !fifo_empty || (state != IDLE);

   alu_cmd_fifo #(.W(11), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (cmd_valid),
      .pop    (issue_vld),
      .wr_dat (cmd_data),
      .rd_dat (head_dat),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue_vld) begin
                  alu_a   <= head_dat[3:0];
                  alu_b   <= head_dat[7:4];
                  alu_op  <= head_dat[10:8];
                  lat_cnt <= 4'(ALU_LATENCY);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 4'd1;
               // Count of 1 marks the edge exactly ALU_LATENCY edges after the operand load.
               if (lat_cnt == 4'd1) begin
                  rsp_data  <= alu_result;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_count <= rsp_count + 8'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: main instance at ALU_LATENCY=2 plus latency-1 and latency-4 instances.
module tb_alu_cmd_issuer;
   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [10:0] cmd_data;
   logic        cmd_ready;
   logic [3:0]  alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [7:0]  alu_result;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_ready;
   logic        busy;
   logic [7:0]  rsp_count;

   logic        sw_valid;
   logic [10:0] sw_data;
   logic        sw_rsp_ready;
   logic        l1_cmd_ready, l4_cmd_ready;
   logic [3:0]  l1_a, l1_b, l4_a, l4_b;
   logic [2:0]  l1_op, l4_op;
   logic [7:0]  l1_res, l4_res;
   logic        l1_rsp_valid, l4_rsp_valid;
   logic [7:0]  l1_rsp_data, l4_rsp_data;
   logic        l1_busy, l4_busy;
   logic [7:0]  l1_rsp_count, l4_rsp_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [10:0] cmd_q[$];
   logic [7:0]  exp_q[$];

   // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 mul, 6 {b,a}, 7 {a,b}.
   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         3'd0:    return {4'd0, a} + {4'd0, b};
         3'd1:    return {4'd0, a} - {4'd0, b};
         3'd2:    return {4'd0, a & b};
         3'd3:    return {4'd0, a | b};
         3'd4:    return {4'd0, a ^ b};
         3'd5:    return {4'd0, a} * {4'd0, b};
         3'd6:    return {b, a};
         default: return {a, b};
      endcase
   endfunction

   // ALU models: one register stage at latency 2, combinational at 1, three stages at 4.
   logic [7:0] alu_reg = 8'd0;
   logic [7:0] p1 = 8'd0, p2 = 8'd0, p3 = 8'd0;
   always @(posedge clk) begin
      alu_reg <= alu_f(alu_a, alu_b, alu_op);
      p1 <= alu_f(l4_a, l4_b, l4_op);
      p2 <= p1;
      p3 <= p2;
   end
   assign alu_result = alu_reg;
   assign l1_res     = alu_f(l1_a, l1_b, l1_op);
   assign l4_res     = p3;

   alu_cmd_issuer #(.DEPTH(4), .ALU_LATENCY(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .busy(busy), .rsp_count(rsp_count)
   );

   alu_cmd_issuer #(.DEPTH(4), .ALU_LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(sw_valid), .cmd_data(sw_data), .cmd_ready(l1_cmd_ready),
      .alu_a(l1_a), .alu_b(l1_b), .alu_op(l1_op), .alu_result(l1_res),
      .rsp_valid(l1_rsp_valid), .rsp_data(l1_rsp_data), .rsp_ready(sw_rsp_ready),
      .busy(l1_busy), .rsp_count(l1_rsp_count)
   );

   alu_cmd_issuer #(.DEPTH(4), .ALU_LATENCY(4)) u_l4 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(sw_valid), .cmd_data(sw_data), .cmd_ready(l4_cmd_ready),
      .alu_a(l4_a), .alu_b(l4_b), .alu_op(l4_op), .alu_result(l4_res),
      .rsp_valid(l4_rsp_valid), .rsp_data(l4_rsp_data), .rsp_ready(sw_rsp_ready),
      .busy(l4_busy), .rsp_count(l4_rsp_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds cmd_q into the main DUT and checks every response against exp_q, in order.
   task automatic pump(input int budget);
      int  cyc;
      logic push, hs;
      cyc = 0;
      while ((cmd_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         cmd_valid = (cmd_q.size() > 0);
         if (cmd_valid) cmd_data = cmd_q[0];
         push = cmd_valid && cmd_ready;
         hs   = rsp_valid && rsp_ready;
         if (hs) begin
            if (exp_q.size() > 0) begin
               chk("rsp_order", {24'd0, rsp_data}, {24'd0, exp_q[0]});
               void'(exp_q.pop_front());
            end else begin
               chk("extra_rsp", {31'd0, rsp_valid}, 32'd0);
            end
         end
         tick();
         if (push) void'(cmd_q.pop_front());
         cyc++;
      end
      cmd_valid = 1'b0;
      chk("pump_timeout", {31'd0, (cmd_q.size() == 0 && exp_q.size() == 0)}, 32'd1);
   endtask

   initial begin
      logic [10:0] c;
      logic        push;
      logic [3:0]  a;
      int          n1, n4, last1, last4;
      logic [7:0]  sw_exp[3];

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
      sw_valid = 1'b0; sw_data = '0; sw_rsp_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
      chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
      chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
      chk("rst_rsp_count", {24'd0, rsp_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single command: 3 + 5 = 8
      cmd_valid = 1'b1; cmd_data = {3'd0, 4'd5, 4'd3}; rsp_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("one_busy_queued", {31'd0, busy}, 32'd1);
      chk("one_alu_a_pre", {28'd0, alu_a}, 32'd0);
      tick();
      chk("one_alu_a", {28'd0, alu_a}, 32'd3);
      chk("one_alu_b", {28'd0, alu_b}, 32'd5);
      chk("one_alu_op", {29'd0, alu_op}, 32'd0);
      chk("one_vld_e0", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("one_vld_e1", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("one_vld_e2", {31'd0, rsp_valid}, 32'd1);
      chk("one_data", {24'd0, rsp_data}, 32'h08);
      chk("one_count_pre", {24'd0, rsp_count}, 32'd0);
      tick();
      chk("one_vld_done", {31'd0, rsp_valid}, 32'd0);
      chk("one_count", {24'd0, rsp_count}, 32'd1);
      chk("one_busy_done", {31'd0, busy}, 32'd0);

      // Asynchronous reset in WAIT
      cmd_valid = 1'b1; cmd_data = {3'd1, 4'd2, 4'd7};
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("arst_alu_a_pre", {28'd0, alu_a}, 32'd7);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_alu_a", {28'd0, alu_a}, 32'd0);
      chk("arst_alu_b", {28'd0, alu_b}, 32'd0);
      chk("arst_alu_op", {29'd0, alu_op}, 32'd0);
      chk("arst_count", {24'd0, rsp_count}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      #1 rst_n = 1'b1;
      repeat (5) tick();
      chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("arst_no_count", {24'd0, rsp_count}, 32'd0);

      // FIFO full with rsp_ready low, then backpressure hold
      for (int i = 0; i < 6; i++) begin
         c = {3'(i), 4'(i + 2), 4'(9 - i)};
         cmd_q.push_back(c);
         exp_q.push_back(alu_f(c[3:0], c[7:4], c[10:8]));
      end
      rsp_ready = 1'b0;
      repeat (8) begin
         cmd_valid = 1'b1;
         cmd_data  = cmd_q[0];
         push = cmd_ready;
         tick();
         if (push) void'(cmd_q.pop_front());
      end
      chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("full_busy", {31'd0, busy}, 32'd1);
      chk("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("full_rsp_data", {24'd0, rsp_data}, 32'h0B);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_rsp_data", {24'd0, rsp_data}, 32'h0B);
      end
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_alu_a", {28'd0, alu_a}, 32'd9);
      chk("bp_alu_b", {28'd0, alu_b}, 32'd2);
      chk("bp_no_pop", {31'd0, cmd_ready}, 32'd0);
      chk("bp_count", {24'd0, rsp_count}, 32'd0);
      rsp_ready = 1'b1;
      pump(200);
      chk("full_count", {24'd0, rsp_count}, 32'd6);
      chk("full_busy_done", {31'd0, busy}, 32'd0);

      // 256 commands: pointers and rsp_count wrap
      for (int i = 0; i < 256; i++) begin
         a = 4'(i % 16);
         c = {3'(i % 8), 4'd15 - a, a};
         cmd_q.push_back(c);
         exp_q.push_back(alu_f(c[3:0], c[7:4], c[10:8]));
      end
      pump(3000);
      chk("wrap_count", {24'd0, rsp_count}, 32'd6);
      chk("wrap_busy", {31'd0, busy}, 32'd0);

      // Latency sweep: 1+2=3, 4*3=0C, A^F=05
      sw_exp[0] = 8'h03; sw_exp[1] = 8'h0C; sw_exp[2] = 8'h05;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       sw_data = {3'd0, 4'd1, 4'd2};
            1:       sw_data = {3'd5, 4'd3, 4'd4};
            default: sw_data = {3'd4, 4'hF, 4'hA};
         endcase
         sw_valid = 1'b1;
         chk("sw_l1_ready", {31'd0, l1_cmd_ready}, 32'd1);
         chk("sw_l4_ready", {31'd0, l4_cmd_ready}, 32'd1);
         tick();
      end
      sw_valid = 1'b0;
      n1 = 0; n4 = 0; last1 = 0; last4 = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (l1_rsp_valid && n1 < 3) begin
            chk("l1_data", {24'd0, l1_rsp_data}, {24'd0, sw_exp[n1]});
            if (n1 > 0) chk("l1_spacing", cyc - last1, 32'd3);
            last1 = cyc;
            n1++;
         end
         if (l4_rsp_valid && n4 < 3) begin
            chk("l4_data", {24'd0, l4_rsp_data}, {24'd0, sw_exp[n4]});
            if (n4 > 0) chk("l4_spacing", cyc - last4, 32'd6);
            last4 = cyc;
            n4++;
         end
         tick();
      end
      chk("l1_rsp_total", n1, 32'd3);
      chk("l4_rsp_total", n4, 32'd3);
      chk("l1_count", {24'd0, l1_rsp_count}, 32'd3);
      chk("l4_count", {24'd0, l4_rsp_count}, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Operand-side counterpart of the 4-bit ALU. Accepts (A, B, op) commands over a valid/ready interface and buffers them in a small FIFO.
- Drives one command at a time onto the ALU operand pins and holds them stable. Samples the ALU's 8-bit result after a fixed latency.
- Returns each result over a valid/ready response interface in command order.
- Sits between a command source (host/scan logic) and the ALU instance in the Tiny Tapeout top.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- ALU_LATENCY, 2, clock edges from the edge that updates alu_a/alu_b/alu_op to the edge that samples alu_result; 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_data  input  11  {op[2:0], B[3:0], A[3:0]}; A = bits 3:0, B = bits 7:4, op = bits 10:8.
- cmd_ready  output  1  FIFO can accept a command.
- alu_a  output  4  operand A to ALU.
- alu_b  output  4  operand B to ALU.
- alu_op  output  3  opcode to ALU.
- alu_result  input  8  ALU result.
- rsp_valid  output  1  response present.
- rsp_data  output  8  captured ALU result.
- rsp_ready  input  1  response consumer accepts.
- busy  output  1  high when FIFO is non-empty or FSM is not IDLE.
- rsp_count  output  8  number of completed response handshakes, wraps 255->0.

Behaviour:
- Reset is asynchronous, active-low: one clock, reset asserted whenever rst_n=0, independent of clk.
- Reset values:
  - FIFO empty; cmd_ready=1.
  - alu_a=0, alu_b=0, alu_op=0.
  - rsp_valid=0, rsp_data=0, rsp_count=0, busy=0.
  - FSM in IDLE.
- Reset mid-operation drops all queued and in-flight commands; no response is produced for them.
- Command FIFO:
  - Push occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full and is registered-state derived; it has no combinational path from cmd_valid.
  - When full, a push is refused even if a pop happens in the same cycle.
  - When not full, a push and a pop in the same cycle are both performed; occupancy is unchanged.
  - Read and write pointers wrap modulo DEPTH. A full/empty ambiguity bit or count is required.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If FIFO is non-empty, pop the head at the edge, load alu_a/alu_b/alu_op from it, load the latency counter with ALU_LATENCY, and go to WAIT.
  - If FIFO is empty, stay in IDLE; operand outputs hold their last values.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter equals 1: rsp_data <= alu_result, rsp_valid <= 1, go to RESP.
  - With ALU_LATENCY=1, this is the first edge after entry.
  - Operands stay stable for the whole of WAIT and RESP.
- RESP:
  - rsp_valid=1 and rsp_data hold until rsp_ready=1.
  - On handshake: rsp_valid <= 0, rsp_count <= rsp_count+1, go to IDLE.
  - The next command issues from IDLE on the following edge, so there is a one-cycle bubble between commands.
- Throughput: one command per ALU_LATENCY+2 cycles when rsp_ready is held high.
- Order: responses are strictly in command order; no reordering or dropping.
- rsp_ready when rsp_valid=0 is ignored.
- busy = (FIFO non-empty) || (state != IDLE).

Test Plan:
- Reset state: hold rst_n=0 and toggle clk -> all outputs at reset values, cmd_ready=1. Then assert rst_n=0 asynchronously mid-WAIT -> rsp_valid and alu_* go to 0 immediately, with no clock edge.
- Single command: push A=3, B=5, op=0 (ALU add, result 8'h08), rsp_ready=1 -> alu_a=3, alu_b=5 one edge after push. rsp_valid rises ALU_LATENCY edges after the operand update with rsp_data=8'h08. rsp_count goes 0->1.
- FIFO full: rsp_ready=0, push 6 commands back-to-back -> first pops into WAIT, next 4 fill the FIFO, cmd_ready=0 and 6th stalls. Then release rsp_ready -> all 6 responses return in order.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_data stable, alu_* stable, no further pop. Then assert rsp_ready -> single handshake, rsp_count +1.
- Wrap: issue 256 commands cycling A=0..15, B=15..0 -> rsp_count returns to 0, FIFO pointers wrap with no loss. Every rsp_data matches the reference ALU model.
- Latency sweep: ALU_LATENCY=1 and 4 with a modelled registered ALU -> sample aligns to the expected result in each case, and command spacing = ALU_LATENCY+2 cycles.
